grover_measure: RTL
===================

Name: grover_measure

Overview:
- Downstream readout stage for grover_search.
- On the rising edge of grover_search's done, it captures the final amplitude vector. It then converts each signed fixed-point amplitude to a probability (amplitude squared), one sample per cycle, through a single shared multiplier.
- It streams the probabilities out, accumulates their total for a normalisation check, and reports the most probable basis state as the measurement result.

Parameters:
- num_bit, 3, number of qubits; width of basis-state index.
- fixedpoint_bit, 24, width of each signed amplitude and of each probability.
- frac_bit, 22, fractional bits of the amplitude/probability format (Q2.22 at defaults; 1.0 = 0x400000).
- num_sample, 2**num_bit, number of amplitudes.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- done_in  in  1  done from grover_search; a level, only its rising edge is used.
- amp_in  in  fixedpoint_bit x [0:num_sample-1]  signed amplitude array from grover_search output_r.
- idle  out  1  high in IDLE.
- prob_out  out  fixedpoint_bit  unsigned probability of sample prob_idx.
- prob_idx  out  num_bit  index of prob_out.
- prob_valid  out  1  prob_out/prob_idx valid this cycle.
- meas_index  out  num_bit  index of maximum probability.
- meas_prob  out  fixedpoint_bit  maximum probability.
- prob_sum  out  fixedpoint_bit+num_bit  sum of all probabilities.
- meas_valid  out  1  one-cycle pulse; meas_* and prob_sum are final.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0 except idle=1.
  - state=IDLE; done_d=0; capture registers, index counter, running max and sum all cleared.
  - Reset mid-operation aborts the scan; no partial meas_valid is produced.
- Edge detect: edge = done_in & ~done_d; done_d is registered every cycle.
  - Because done_d resets to 0, done_in high at the first posedge after reset counts as an edge.
- FSM has three states: IDLE, SCAN, REPORT.
- IDLE:
  - On edge at posedge P: latch all amp_in, clear cnt/max/sum, go to SCAN.
  - idle drops at P.
- SCAN (num_sample cycles):
  - At each posedge, compute sq = amp_cap[cnt]*amp_cap[cnt] (2*fixedpoint_bit signed product, always >= 0), then p = sq >> frac_bit (truncation).
  - If p > 2^(fixedpoint_bit-1)-1, saturate to that value.
  - Register prob_out=p, prob_idx=cnt, prob_valid=1; sum += p.
  - If p > max (strict), set max=p and maxidx=cnt. Ties therefore keep the lowest index; cnt=0 always loads.
  - cnt wraps from num_sample-1 to REPORT.
  - prob_valid is high at posedges P+1 .. P+num_sample and low otherwise.
- REPORT (one cycle, posedge P+num_sample+1):
  - meas_index=maxidx, meas_prob=max, prob_sum=sum, meas_valid=1, prob_valid=0; go to IDLE, idle=1.
- meas_index, meas_prob and prob_sum hold until the next REPORT or reset; meas_valid is a single-cycle pulse.
- Edges of done_in during SCAN/REPORT are ignored; the captured vector stays stable and amp_in changes do not affect the scan.
- A new scan starts only on an edge seen while in IDLE. done_in held high continuously yields exactly one scan.
- Total latency from the capture edge to meas_valid is num_sample+1 cycles (9 at defaults).

Test Plan:
- Defaults. amp[5]=0x400000, others 0, done_in 0->1:
  - prob_valid for 8 cycles starting 1 cycle after capture, prob_idx 0..7.
  - prob_out=0x400000 at idx 5, 0 elsewhere.
  - meas_valid 9 cycles after capture with meas_index=5, meas_prob=0x400000, prob_sum=0x400000.
- Uniform superposition: all amp=0x16A09E:
  - Every prob_out=0x07FFFF.
  - meas_index=0 (tie rule), prob_sum=0x3FFFF8.
- Signs: amp[2]=0xC00000 (-1.0), amp[6]=0x200000 (0.5), others 0:
  - prob 0x400000 at idx 2, 0x100000 at idx 6.
  - meas_index=2, prob_sum=0x500000.
- Saturation: amp[1]=0x800000 (-2.0):
  - prob_out at idx 1 = 0x7FFFFF; meas_index=1, meas_prob=0x7FFFFF.
- Handshake:
  - done_in held high for 30 cycles gives exactly one meas_valid.
  - done_in toggled 0->1 at scan cycle 3 with a changed amp_in gives results from the original capture and no second scan.
  - A later edge in IDLE starts a new scan.
- Reset: rst=0 asserted asynchronously at scan cycle 4:
  - All outputs 0 and idle=1 immediately; no meas_valid.
  - After release, the first cycle with done_in=1 starts a clean scan with correct results.

Source files
------------

// File: rtl/grover_measure.sv
// Readout stage for grover_search: captures the final amplitude vector on done,
// squares each amplitude into a probability, streams them out and reports the argmax.
module grover_measure #(
  parameter int num_bit        = 3,
  parameter int fixedpoint_bit = 24,
  parameter int frac_bit       = 22,
  parameter int num_sample     = 2**num_bit
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                done_in,
  input  logic signed [fixedpoint_bit-1:0]    amp_in [num_sample],
  output logic                                idle,
  output logic [fixedpoint_bit-1:0]           prob_out,
  output logic [num_bit-1:0]                  prob_idx,
  output logic                                prob_valid,
  output logic [num_bit-1:0]                  meas_index,
  output logic [fixedpoint_bit-1:0]           meas_prob,
  output logic [fixedpoint_bit+num_bit-1:0]   prob_sum,
  output logic                                meas_valid
);

  localparam int sq_w  = 2*fixedpoint_bit;
  localparam int sh_w  = sq_w - frac_bit;
  localparam int sum_w = fixedpoint_bit + num_bit;
  localparam logic [fixedpoint_bit-1:0] sat_val = {1'b0, {(fixedpoint_bit-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t                            state_reg, state_next;
  logic                              done_d_reg;
  logic                              edge_det;
  logic                              load;
  logic signed [fixedpoint_bit-1:0]  amp_cap_reg  [num_sample];
  logic signed [fixedpoint_bit-1:0]  amp_cap_next [num_sample];
  logic [num_bit-1:0]                cnt_reg;
  logic [fixedpoint_bit-1:0]         max_reg;
  logic [num_bit-1:0]                maxidx_reg;
  logic [sum_w-1:0]                  sum_reg;
  logic signed [fixedpoint_bit-1:0]  cur_amp;
  logic signed [sq_w-1:0]            sq;
  logic [sh_w-1:0]                   sq_shift;
  logic [fixedpoint_bit-1:0]         p;

  assign edge_det = done_in & ~done_d_reg;
  assign load     = (state_reg == IDLE) && edge_det;

  generate
    for (genvar gi = 0; gi < num_sample; gi++) begin : g_cap
      assign amp_cap_next[gi] = load ? amp_in[gi] : amp_cap_reg[gi];
    end
  endgenerate

  // Square is never negative, so only the upper bound needs clamping.
  assign cur_amp  = amp_cap_reg[cnt_reg];
  assign sq       = sq_w'(cur_amp) * sq_w'(cur_amp);
  assign sq_shift = sq[sq_w-1:frac_bit];
  assign p        = (sq_shift > sh_w'(sat_val)) ? sat_val : sq_shift[fixedpoint_bit-1:0];

  always_comb begin
    state_next = state_reg;
    idle       = (state_reg == IDLE);
    case (state_reg)
      IDLE:    if (edge_det) state_next = SCAN;
      SCAN:    if (cnt_reg == num_bit'(num_sample-1)) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amp_cap_reg <= '{default: '0};
    end else begin
      amp_cap_reg <= amp_cap_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      done_d_reg <= 1'b0;
      cnt_reg    <= '0;
      max_reg    <= '0;
      maxidx_reg <= '0;
      sum_reg    <= '0;
      prob_out   <= '0;
      prob_idx   <= '0;
      prob_valid <= 1'b0;
      meas_index <= '0;
      meas_prob  <= '0;
      prob_sum   <= '0;
      meas_valid <= 1'b0;
    end else begin
      state_reg  <= state_next;
      done_d_reg <= done_in;
      prob_valid <= 1'b0;
      meas_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (edge_det) begin
            cnt_reg    <= '0;
            max_reg    <= '0;
            maxidx_reg <= '0;
            sum_reg    <= '0;
          end
        end
        SCAN: begin
          prob_out   <= p;
          prob_idx   <= cnt_reg;
          prob_valid <= 1'b1;
          sum_reg    <= sum_reg + sum_w'(p);
          // Strict compare keeps the lowest index on ties.
          if (p > max_reg) begin
            max_reg    <= p;
            maxidx_reg <= cnt_reg;
          end
          cnt_reg <= cnt_reg + num_bit'(1);
        end
        REPORT: begin
          meas_index <= maxidx_reg;
          meas_prob  <= max_reg;
          prob_sum   <= sum_reg;
          meas_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
